enc_codeword_gen_16bit: RTL and testbench
=========================================

Name: enc_codeword_gen_16bit

Overview:
- Encoder for the team's 16-bit extended-Hamming (SECDED) code. Converts an 11-bit data word into a 16-bit codeword that the decoder's syndrome multiplier maps to syndrome 5'b00000.
- Two-stage pipeline with valid/ready handshakes on input and output.
- Optional per-word error-mask injection, so decoder benches can be fed deliberately corrupted codewords.
- Saturating count of delivered codewords.

Parameters:
- COUNT_WIDTH, 16, width of the delivered-codeword counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset
- data_in  input  11  data word to encode
- data_valid  input  1  data_in/err_mask/inject_en valid
- data_ready  output  1  encoder accepts input this cycle
- err_mask  input  16  bits XORed into the codeword when inject_en=1
- inject_en  input  1  apply err_mask to this word
- codeword_out  output  16  encoded (possibly corrupted) codeword
- codeword_valid  output  1  codeword_out valid
- codeword_ready  input  1  downstream accepts codeword
- enc_count  output  COUNT_WIDTH  codewords delivered, saturating

Behaviour:
- Codeword mapping, with c = codeword before injection:
  - c[5+i] = data_in[i], for i=0..10.
  - c[0] = c5^c6^c8^c9^c11^c13^c15
  - c[1] = c5^c7^c8^c10^c11^c14^c15
  - c[2] = c6^c7^c8^c12^c13^c14^c15
  - c[3] = c9^c10^c11^c12^c13^c14^c15
  - c[4] = XOR of c[0..3] and c[5..15], giving even overall parity.
- Invariant: with inject_en=0, the decoder syndrome of codeword_out is 0.
- Stage 1 (s1), on input accept:
  - registers c[0..3] and c[5..15].
  - registers the mask as inject_en ? err_mask : 16'h0000.
  - sets s1_valid.
- Stage 2 (s2), on s1 advance:
  - computes c[4].
  - registers codeword_out = c ^ mask.
  - sets s2_valid (= codeword_valid).
- Handshake:
  - s2_adv = ~s2_valid | codeword_ready
  - s1_adv = ~s1_valid | s2_adv
  - data_ready = s1_adv (combinational).
  - Input accepted when data_valid & data_ready.
  - Output transfer when codeword_valid & codeword_ready.
- Latency: an accepted word appears on codeword_out 2 cycles later if there is no backpressure.
- Throughput: 1 word/cycle under continuous valid and ready.
- Stall: while codeword_valid=1 and codeword_ready=0, codeword_out and codeword_valid hold stable. s1 holds if full. data_ready=0 once both stages are full.
- Bubbles: if s1 advances while s1_valid=0 (empty), s2_valid clears on that edge unless new data moves in. Data registers need not clear, but codeword_valid must deassert.
- Simultaneous accept and output transfer: allowed in the same cycle, with no bubble inserted.
- data_valid deasserting without a handshake is legal. The encoder ignores data_in when data_valid=0.
- enc_count:
  - increments by 1 on each output transfer.
  - saturates at 2^COUNT_WIDTH-1 and never wraps.
- Reset (asynchronous assert, any time, including mid-transfer):
  - codeword_valid=0, s1_valid=0, codeword_out=16'h0000, enc_count=0.
  - data_ready=1 during and after reset. It is combinational from cleared valids.
  - In-flight words are discarded.
- Deassertion is synchronous to clk via the team's standard reset synchroniser outside this block. First accept is possible on the first clk edge after rst rises.

Test Plan:
- Reset, then data_in=11'h000, inject_en=0, codeword_ready=1 -> codeword_out=16'h0000, valid 2 cycles after accept; enc_count=1.
- data_in=11'h001 -> codeword_out=16'h0033. data_in=11'h7FF -> codeword_out=16'hFFFF.
- Back-to-back 11'h001, 11'h7FF, 11'h000 with codeword_ready=1 -> 16'h0033, 16'hFFFF, 16'h0000 on 3 consecutive cycles; data_ready stays 1.
- codeword_ready=0 with 3 words offered:
  - 2 words accepted, then data_ready=0; codeword_out is held stable.
  - Release ready -> words exit in order, no loss or duplication.
- data_in=11'h000, inject_en=1, err_mask=16'h0100 -> codeword_out=16'h0100; decoder syndrome is nonzero with mul_result[4]=1.
- Random 10k words, random backpressure, inject_en=0 -> every output has zero syndrome and matches the reference model.
- Assert rst with both stages full -> codeword_valid=0 immediately, enc_count=0, data_ready=1.

Source files
------------

// File: rtl/enc_codeword_gen_16bit.sv
// 16-bit extended-Hamming (SECDED) codeword generator.
// Two-stage valid/ready pipeline with error-mask injection and a saturating count.

package enc_codeword_gen_16bit_pkg;

    typedef struct packed {
        logic [15:0] cw;
        logic [15:0] mask;
    } enc_s1_t;

endpackage

module enc_codeword_gen_16bit
    import enc_codeword_gen_16bit_pkg::*;
#(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [10:0]            data_in,
    input  logic                   data_valid,
    output logic                   data_ready,
    input  logic [15:0]            err_mask,
    input  logic                   inject_en,
    output logic [15:0]            codeword_out,
    output logic                   codeword_valid,
    input  logic                   codeword_ready,
    output logic [COUNT_WIDTH-1:0] enc_count
);

    logic        s1_valid;
    enc_s1_t     s1;
    logic        s2_valid;
    logic        s1_adv;
    logic        s2_adv;
    logic [15:0] c_in;
    logic [15:0] c_full;

    assign s2_adv         = ~s2_valid | codeword_ready;
    assign s1_adv         = ~s1_valid | s2_adv;
    assign data_ready     = s1_adv;
    assign codeword_valid = s2_valid;

    // Bit 4 is left zero here; overall parity is folded in at stage 2.
    always_comb begin
        c_in       = '0;
        c_in[15:5] = data_in;
        c_in[0]    = c_in[5] ^ c_in[6] ^ c_in[8] ^ c_in[9]
                   ^ c_in[11] ^ c_in[13] ^ c_in[15];
        c_in[1]    = c_in[5] ^ c_in[7] ^ c_in[8] ^ c_in[10]
                   ^ c_in[11] ^ c_in[14] ^ c_in[15];
        c_in[2]    = c_in[6] ^ c_in[7] ^ c_in[8] ^ c_in[12]
                   ^ c_in[13] ^ c_in[14] ^ c_in[15];
        c_in[3]    = c_in[9] ^ c_in[10] ^ c_in[11] ^ c_in[12]
                   ^ c_in[13] ^ c_in[14] ^ c_in[15];
    end

    always_comb begin
        c_full    = s1.cw;
        c_full[4] = ^{s1.cw[15:5], s1.cw[3:0]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else if (s1_adv) begin
            s1_valid <= data_valid;
            if (data_valid) begin
                s1.cw   <= c_in;
                s1.mask <= inject_en ? err_mask : 16'h0000;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid     <= 1'b0;
            codeword_out <= 16'h0000;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                codeword_out <= c_full ^ s1.mask;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enc_count <= '0;
        end else if (s2_valid && codeword_ready && (enc_count != '1)) begin
            enc_count <= enc_count + COUNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_enc_codeword_gen_16bit.sv
// Scoreboard bench for enc_codeword_gen_16bit.
// Reference encoder is built from Hamming positions, independent of the RTL equations.

module tb_enc_codeword_gen_16bit;

    typedef struct {
        logic [15:0] cw;
        bit          inj;
    } sb_t;

    localparam int HPOS [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

    logic        clk;
    logic        rst;
    logic [10:0] data_in;
    logic        data_valid;
    logic        data_ready;
    logic [15:0] err_mask;
    logic        inject_en;
    logic [15:0] codeword_out;
    logic        codeword_valid;
    logic        codeword_ready;
    logic [15:0] enc_count;

    logic        sat_data_ready;
    logic [15:0] sat_codeword_out;
    logic        sat_codeword_valid;
    logic [1:0]  sat_enc_count;

    sb_t         q[$];
    int          n_checks;
    int          n_pass;
    int          exp_count;

    enc_codeword_gen_16bit #(.COUNT_WIDTH(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .data_valid     (data_valid),
        .data_ready     (data_ready),
        .err_mask       (err_mask),
        .inject_en      (inject_en),
        .codeword_out   (codeword_out),
        .codeword_valid (codeword_valid),
        .codeword_ready (codeword_ready),
        .enc_count      (enc_count)
    );

    enc_codeword_gen_16bit #(.COUNT_WIDTH(2)) dut_sat (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .data_valid     (data_valid),
        .data_ready     (sat_data_ready),
        .err_mask       (err_mask),
        .inject_en      (inject_en),
        .codeword_out   (sat_codeword_out),
        .codeword_valid (sat_codeword_valid),
        .codeword_ready (codeword_ready),
        .enc_count      (sat_enc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [15:0] ref_enc(input logic [10:0] d);
        logic [15:0] cw;
        int h;
        cw = '0;
        cw[15:5] = d;
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 11; i++) begin
                h = HPOS[i];
                if (h[p]) cw[p] = cw[p] ^ d[i];
            end
        end
        cw[4] = ^cw;
        return cw;
    endfunction

    function automatic logic [4:0] syndrome(input logic [15:0] cw);
        logic [4:0] s;
        int h;
        s = '0;
        for (int p = 0; p < 4; p++) begin
            s[p] = cw[p];
            for (int i = 0; i < 11; i++) begin
                h = HPOS[i];
                if (h[p]) s[p] = s[p] ^ cw[5+i];
            end
        end
        s[4] = ^cw;
        return s;
    endfunction

    // Scoreboard: compare outputs, then capture accepted inputs.
    always @(negedge clk) begin
        sb_t e;
        logic [4:0] s;
        if (rst) begin
            if (codeword_valid && codeword_ready) begin
                if (exp_count != 65535) exp_count++;
                if (q.size() == 0) begin
                    check("sb_unexpected", {16'h0, codeword_out}, 32'hDEAD);
                end else begin
                    e = q.pop_front();
                    s = syndrome(codeword_out);
                    check("cw", {16'h0, codeword_out}, {16'h0, e.cw});
                    if (e.inj) check("syn4_inj", {31'h0, s[4]}, 32'h1);
                    else check("syn_zero", {27'h0, s}, 32'h0);
                end
            end
            if (data_valid && data_ready) begin
                e.cw  = ref_enc(data_in) ^ (inject_en ? err_mask : 16'h0);
                e.inj = inject_en;
                q.push_back(e);
            end
        end
    end

    task automatic send(input logic [10:0] d, input logic inj,
                        input logic [15:0] m, output int waits);
        data_in    = d;
        inject_en  = inj;
        err_mask   = m;
        data_valid = 1'b1;
        waits      = 0;
        @(negedge clk);
        while (!data_ready && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 200) check("send_timeout", waits, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || codeword_valid) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", q.size(), 0);
    endtask

    initial begin
        int w;
        int sent;
        int cyc;
        bit acc;
        n_checks       = 0;
        n_pass         = 0;
        exp_count      = 0;
        rst            = 1'b0;
        data_in        = '0;
        data_valid     = 1'b0;
        err_mask       = '0;
        inject_en      = 1'b0;
        codeword_ready = 1'b1;
        #1;
        check("rst_valid", codeword_valid, 0);
        check("rst_ready", data_ready, 1);
        check("rst_cw", codeword_out, 0);
        check("rst_cnt", enc_count, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        send(11'h000, 1'b0, 16'h0, w);
        data_valid = 1'b0;
        check("lat_v0", codeword_valid, 0);
        @(posedge clk);
        #1;
        check("lat_v1", codeword_valid, 1);
        check("lat_cw", codeword_out, 16'h0000);
        @(posedge clk);
        #1;
        check("lat_cnt", enc_count, 1);

        send(11'h001, 1'b0, 16'h0, w);
        check("b2b_w1", w, 0);
        send(11'h7FF, 1'b0, 16'h0, w);
        check("b2b_w2", w, 0);
        check("b2b_v1", codeword_valid, 1);
        check("b2b_c1", codeword_out, 16'h0033);
        send(11'h000, 1'b0, 16'h0, w);
        check("b2b_w3", w, 0);
        check("b2b_v2", codeword_valid, 1);
        check("b2b_c2", codeword_out, 16'hFFFF);
        data_valid = 1'b0;
        @(posedge clk);
        #1;
        check("b2b_v3", codeword_valid, 1);
        check("b2b_c3", codeword_out, 16'h0000);
        drain();

        codeword_ready = 1'b0;
        send(11'h123, 1'b0, 16'h0, w);
        send(11'h456, 1'b0, 16'h0, w);
        data_in = 11'h789;
        repeat (4) begin
            @(negedge clk);
            check("stall_ready", data_ready, 0);
            check("stall_valid", codeword_valid, 1);
            check("stall_hold", codeword_out, ref_enc(11'h123));
        end
        @(posedge clk);
        #1;
        codeword_ready = 1'b1;
        send(11'h789, 1'b0, 16'h0, w);
        data_valid = 1'b0;
        drain();

        send(11'h000, 1'b1, 16'h0100, w);
        data_valid = 1'b0;
        inject_en  = 1'b0;
        err_mask   = 16'h0;
        @(posedge clk);
        #1;
        check("inj_cw", codeword_out, 16'h0100);
        check("inj_syn_nz", syndrome(codeword_out) != 0, 1);
        drain();

        sent = 0;
        cyc  = 0;
        while ((sent < 10000 || data_valid) && cyc < 60000) begin
            @(negedge clk);
            acc = data_valid && data_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (acc) sent++;
            codeword_ready = ($urandom_range(0, 3) != 0);
            if (!data_valid || acc) begin
                if (sent < 10000 && $urandom_range(0, 4) != 0) begin
                    data_in    = 11'($urandom_range(0, 2047));
                    data_valid = 1'b1;
                end else begin
                    data_valid = 1'b0;
                end
            end
        end
        check("rnd_sent", sent, 10000);
        codeword_ready = 1'b1;
        drain();
        check("cnt_total", enc_count, exp_count);
        check("cnt_sat", sat_enc_count, 3);

        codeword_ready = 1'b0;
        send(11'h2AA, 1'b0, 16'h0, w);
        send(11'h155, 1'b0, 16'h0, w);
        data_valid = 1'b0;
        check("full_ready", data_ready, 0);
        #3;
        rst = 1'b0;
        #1;
        q.delete();
        exp_count = 0;
        check("mid_valid", codeword_valid, 0);
        check("mid_cnt", enc_count, 0);
        check("mid_ready", data_ready, 1);
        check("mid_cw", codeword_out, 0);
        check("mid_sat_cnt", sat_enc_count, 0);
        @(negedge clk);
        rst = 1'b1;
        codeword_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_valid", codeword_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
